// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - bundled instruction, data and memory sram-like handshakes
//
// Purpose: carries every non-clock signal of the arbiter so the core-facing
// requesters and the memory-facing port travel as one bundle.
// Port summary:
//   inst_*  : fetch requester (req/addr in, addr_ok/data_ok/rdata out of the arbiter)
//   data_*  : load/store requester (req/wr/wstrb/addr/wdata in, addr_ok/data_ok/rdata out)
//   mem_*   : shared memory port (req/wr/wstrb/addr/wdata out, addr_ok/data_ok/rdata in)
//   busy    : arbiter has a transaction in flight
// Modports:
//   master : the arbiter itself (it masters the memory port)
//   slave  : the surroundings (core requesters plus memory/bus bridge)
interface sram_like_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  inst_req;
  logic [ADDR_W-1:0]     inst_addr;
  logic                  inst_addr_ok;
  logic                  inst_data_ok;
  logic [DATA_W-1:0]     inst_rdata;

  logic                  data_req;
  logic                  data_wr;
  logic [DATA_W/8-1:0]   data_wstrb;
  logic [ADDR_W-1:0]     data_addr;
  logic [DATA_W-1:0]     data_wdata;
  logic                  data_addr_ok;
  logic                  data_data_ok;
  logic [DATA_W-1:0]     data_rdata;

  logic                  mem_req;
  logic                  mem_wr;
  logic [DATA_W/8-1:0]   mem_wstrb;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_addr_ok;
  logic                  mem_data_ok;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata,
    output busy
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one sram-like memory port between fetch and load/store
//
// Purpose: grants the memory port to the data requester by default, forcing
// one fetch grant after FAIR_N consecutive data grants made while a fetch
// was waiting. Only one memory transaction is ever outstanding.
// Port summary:
//   clk  : clock, all state on rising edge
//   rst  : synchronous reset, active-high
//   bus  : sram_like_arbiter_if.master (inst_*, data_*, mem_*, busy)
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR_N = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  sram_like_arbiter_if.master    bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam logic [3:0] FAIR_MAX = 4'(FAIR_N);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t              state;
  logic                gnt;        // 0 = inst, 1 = data
  logic                wr_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          fair_cnt;
  logic                mem_req_q;
  logic                busy_q;

  logic inst_forced;
  logic pick_data;
  logic any_req;

  always_comb begin
    inst_forced = 1'b0;
    pick_data   = 1'b0;
    any_req     = 1'b0;
    // A waiting fetch that has already seen FAIR_N data grants takes this slot.
    inst_forced = bus.inst_req && (fair_cnt == FAIR_MAX);
    pick_data   = bus.data_req && !inst_forced;
    any_req     = bus.inst_req || bus.data_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      wr_q      <= 1'b0;
      wstrb_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fair_cnt  <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ADDR;
            gnt       <= pick_data;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
            if (pick_data) begin
              wr_q    <= bus.data_wr;
              wstrb_q <= bus.data_wstrb;
              addr_q  <= bus.data_addr;
              wdata_q <= bus.data_wdata;
              // Count only data grants that made a fetch wait.
              if (bus.inst_req) begin
                if (fair_cnt != FAIR_MAX) fair_cnt <= fair_cnt + 4'd1;
              end else begin
                fair_cnt <= '0;
              end
            end else begin
              wr_q     <= 1'b0;
              wstrb_q  <= '0;
              addr_q   <= bus.inst_addr;
              wdata_q  <= '0;
              fair_cnt <= '0;
            end
          end
        end
        ADDR: begin
          if (bus.mem_addr_ok) begin
            state     <= DATA;
            mem_req_q <= 1'b0;
          end
        end
        DATA: begin
          if (bus.mem_data_ok) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_wstrb = wstrb_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;

  // Requester handshakes are combinational so they land in the same cycle
  // as the memory-side acknowledge they forward.
  assign bus.inst_addr_ok = (state == ADDR) && !gnt && bus.mem_addr_ok;
  assign bus.data_addr_ok = (state == ADDR) &&  gnt && bus.mem_addr_ok;
  assign bus.inst_data_ok = (state == DATA) && !gnt && bus.mem_data_ok;
  assign bus.data_data_ok = (state == DATA) &&  gnt && bus.mem_data_ok;

  // Stores get the completion pulse only; read data is not forwarded for them.
  assign bus.inst_rdata = bus.inst_data_ok ? bus.mem_rdata : '0;
  assign bus.data_rdata = (bus.data_data_ok && !wr_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - directed and randomized bench for sram_like_arbiter
module tb_sram_like_arbiter;
  localparam int FAIR_N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_like_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .FAIR_N(FAIR_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    waited = 0;     // data grants a pending fetch has sat through
  int    last_grant = 0;
  int    g_prev;
  string order;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Runs one full transaction starting in an idle cycle with requests set.
  task automatic txn(input int aw, input int dw, input logic [31:0] rd, input bit keep);
    bit          exp_d;
    logic [31:0] ea;
    logic        ew;
    logic [3:0]  es;
    logic [31:0] ewd;
    @(negedge clk);
    chk1("idle_busy", bus.busy, 1'b0);
    // Fetch is owed the slot once it has waited out FAIR_N data grants.
    exp_d = bus.data_req && !(bus.inst_req && waited >= FAIR_N);
    if (exp_d) begin
      ea = bus.data_addr; ew = bus.data_wr; es = bus.data_wstrb; ewd = bus.data_wdata;
      waited = bus.inst_req ? waited + 1 : 0;
    end else begin
      ea = bus.inst_addr; ew = 1'b0; es = 4'h0; ewd = 32'h0;
      waited = 0;
    end
    last_grant = cyc;
    tick();
    for (int i = 0; i <= aw; i++) begin
      bus.mem_addr_ok = (i == aw);
      @(negedge clk);
      chk1("mem_req", bus.mem_req, 1'b1);
      chk1("busy_addr", bus.busy, 1'b1);
      chk32("mem_addr", bus.mem_addr, ea);
      chk1("mem_wr", bus.mem_wr, ew);
      chk32("mem_wstrb", 32'(bus.mem_wstrb), 32'(es));
      if (ew) chk32("mem_wdata", bus.mem_wdata, ewd);
      chk1("inst_addr_ok", bus.inst_addr_ok, (i == aw) && !exp_d);
      chk1("data_addr_ok", bus.data_addr_ok, (i == aw) && exp_d);
      if (i == aw) order = {order, bus.data_addr_ok ? "D" : "I"};
      tick();
    end
    bus.mem_addr_ok = 1'b0;
    if (!keep) begin
      if (exp_d) bus.data_req = 1'b0;
      else       bus.inst_req = 1'b0;
    end
    for (int i = 0; i <= dw; i++) begin
      bus.mem_data_ok = (i == dw);
      bus.mem_rdata   = (i == dw) ? rd : $urandom;
      @(negedge clk);
      chk1("mem_req_data", bus.mem_req, 1'b0);
      chk1("busy_data", bus.busy, 1'b1);
      chk1("inst_data_ok", bus.inst_data_ok, (i == dw) && !exp_d);
      chk1("data_data_ok", bus.data_data_ok, (i == dw) && exp_d);
      if (i == dw && !exp_d) chk32("inst_rdata", bus.inst_rdata, rd);
      if (i == dw && exp_d && !ew) chk32("data_rdata", bus.data_rdata, rd);
      if (i < dw) begin
        chk32("inst_rdata_quiet", bus.inst_rdata, 32'h0);
        chk32("data_rdata_quiet", bus.data_rdata, 32'h0);
      end
      tick();
    end
    bus.mem_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.inst_req = 1'b0; bus.inst_addr = 32'h0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_wstrb = 4'h0;
    bus.data_addr = 32'h0; bus.data_wdata = 32'h0;
    bus.mem_addr_ok = 1'b0; bus.mem_data_ok = 1'b0; bus.mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_wr", bus.mem_wr, 1'b0);
    chk32("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'h0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk1("rst_inst_addr_ok", bus.inst_addr_ok, 1'b0);
    chk1("rst_data_addr_ok", bus.data_addr_ok, 1'b0);
    chk1("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
    chk1("rst_data_data_ok", bus.data_data_ok, 1'b0);
    chk32("rst_inst_rdata", bus.inst_rdata, 32'h0);
    chk32("rst_data_rdata", bus.data_rdata, 32'h0);
    tick();

    // Single load.
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h1FC00010;
    txn(0, 0, 32'hDEADBEEF, 0);

    // Store held through three address stalls.
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_wstrb = 4'h3;
    bus.data_addr = 32'h00001000; bus.data_wdata = 32'h12345678;
    txn(3, 1, 32'hCAFEF00D, 0);

    // Simultaneous requests: data first, then the pending fetch.
    order = "";
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00040;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h80000010;
    txn(0, 0, 32'h11111111, 0);
    g_prev = last_grant;
    txn(1, 0, 32'h22222222, 0);
    total++;
    assert (order == "DI") else begin
      bad++;
      $error("FAIL conflict_order observed=%s expected=DI", order);
    end
    chk32("conflict_gap", 32'(last_grant - g_prev), 32'd3);

    // Fairness with both requesters held high.
    order = "";
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00100;
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h80000000;
    for (int n = 0; n < 10; n++) txn(0, 0, $urandom, 1);
    total++;
    assert (order == "DDDDIDDDDI") else begin
      bad++;
      $error("FAIL fair_order observed=%s expected=DDDDIDDDDI", order);
    end
    bus.inst_req = 1'b0; bus.data_req = 1'b0;
    tick();

    // Reset while waiting for read data; the late response must vanish.
    bus.data_req = 1'b1; bus.data_wr = 1'b0; bus.data_addr = 32'h00002000;
    tick();
    bus.mem_addr_ok = 1'b1;
    tick();
    bus.mem_addr_ok = 1'b0; bus.data_req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
    waited = 0;
    @(negedge clk);
    chk1("rstmid_busy", bus.busy, 1'b0);
    chk1("rstmid_mem_req", bus.mem_req, 1'b0);
    chk1("rstmid_data_data_ok", bus.data_data_ok, 1'b0);
    chk1("rstmid_inst_data_ok", bus.inst_data_ok, 1'b0);
    chk32("rstmid_data_rdata", bus.data_rdata, 32'h0);
    tick();
    bus.mem_data_ok = 1'b0;
    tick();

    // Back-to-back zero-wait fetches.
    order = "";
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC00000;
    txn(0, 0, 32'h3C1DBFC0, 1);
    g_prev = last_grant;
    bus.inst_addr = 32'hBFC00004;
    txn(0, 0, 32'h27BDFFF0, 0);
    chk32("fetch_gap", 32'(last_grant - g_prev), 32'd3);
    total++;
    assert (order == "II") else begin
      bad++;
      $error("FAIL fetch_order observed=%s expected=II", order);
    end

    // Randomized traffic; a losing requester keeps its request pending.
    for (int n = 0; n < 60; n++) begin
      if (!bus.inst_req && $urandom_range(0, 1) == 1) begin
        bus.inst_req  = 1'b1;
        bus.inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!bus.data_req && $urandom_range(0, 2) != 0) begin
        bus.data_req   = 1'b1;
        bus.data_wr    = 1'($urandom_range(0, 1));
        bus.data_wstrb = 4'($urandom_range(1, 15));
        bus.data_addr  = $urandom;
        bus.data_wdata = $urandom;
      end
      if (!bus.inst_req && !bus.data_req) begin
        bus.mem_data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk1("rand_idle_busy", bus.busy, 1'b0);
        chk1("rand_idle_mem_req", bus.mem_req, 1'b0);
        chk1("rand_idle_data_ok", bus.data_data_ok | bus.inst_data_ok, 1'b0);
        tick();
        bus.mem_data_ok = 1'b0;
      end else begin
        txn($urandom_range(0, 2), $urandom_range(0, 2), $urandom, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
